// File: rtl/sonar_pkg.sv
// Shared definitions for the SONAR serial word receiver: FSM encoding and default word width.
package sonar_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } sonar_state_t;

   localparam int SONAR_WORD_WIDTH = 16;

endpackage

// File: rtl/sonar_sipo_shift_core.sv
// WIDTH-bit serial-in/parallel-out shift register; serial data enters at bit 0.
module sonar_sipo_shift_core
   import sonar_pkg::*;
#(
   parameter int WIDTH = SONAR_WORD_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             shift_en,
   input  logic             serial_in,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] word_next;

   generate
      if (WIDTH == 1) begin : g_single
         assign word_next = serial_in;
      end else begin : g_multi
         assign word_next = {word[WIDTH-2:0], serial_in};
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         word <= '0;
      end else if (shift_en) begin
         word <= word_next;
      end
   end

endmodule

// File: rtl/sonar_serial_word_receiver.sv
// SONAR serial word receiver: frames MSB-first bits into words and hands them
// to the consumer through a valid/ready holding register with sticky overrun.
//
// state    | meaning
// ST_IDLE  | waiting for a frame_start bit; stray strobes ignored
// ST_SHIFT | collecting bits of a word, count = bits received so far
module sonar_serial_word_receiver
   import sonar_pkg::*;
#(
   parameter int WIDTH = SONAR_WORD_WIDTH,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             bit_enable,
   input  logic             frame_start,
   input  logic             serial_in,
   input  logic             word_ready,
   input  logic             clear_overrun,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   output logic             busy,
   output logic             resync,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

   sonar_state_t     state;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] completed;
   logic             shift_en;
   logic             done;

   sonar_sipo_shift_core #(.WIDTH(WIDTH)) u_shift (
      .clk       (clk),
      .resetn    (resetn),
      .shift_en  (shift_en),
      .serial_in (serial_in),
      .word      (sr)
   );

   // The finished word includes the bit being sampled this cycle.
   generate
      if (WIDTH == 1) begin : g_done_single
         assign completed = serial_in;
      end else begin : g_done_multi
         assign completed = {sr[WIDTH-2:0], serial_in};
      end
   endgenerate

   always_comb begin
      shift_en = bit_enable && (frame_start || (state == ST_SHIFT));
      done     = 1'b0;
      if (bit_enable) begin
         if (state == ST_IDLE)
            done = frame_start && (WIDTH == 1);
         else
            done = !frame_start && (count == LAST_IDX);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= ST_IDLE;
         count      <= '0;
         word_out   <= '0;
         word_valid <= 1'b0;
         busy       <= 1'b0;
         resync     <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         resync <= 1'b0;
         if (clear_overrun)
            overrun <= 1'b0;
         if (word_valid && word_ready)
            word_valid <= 1'b0;

         // A completing word overrides the accept-clear; overrun set beats clear.
         if (done) begin
            if (!word_valid || word_ready) begin
               word_out   <= completed;
               word_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         if (bit_enable) begin
            unique case (state)
               ST_IDLE: begin
                  if (frame_start && (WIDTH > 1)) begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                     count <= CNT_W'(1);
                  end
               end
               ST_SHIFT: begin
                  if (frame_start) begin
                     count  <= CNT_W'(1);
                     resync <= 1'b1;
                  end else if (count == LAST_IDX) begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                     count <= '0;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule
